// File: rtl/seven_seg_scan_ctrl.sv
// Four-digit common-anode 7-segment scan controller with per-digit dead time,
// hex decoding and a frame-synchronous valid/ready update port.
module seven_seg_scan_ctrl #(
    parameter int SCAN_DIV     = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wr_valid,
    output logic        wr_ready,
    input  logic [15:0] wr_data,
    input  logic [3:0]  wr_blank,
    input  logic [3:0]  wr_dp,
    output logic [7:0]  seg_n,
    output logic [3:0]  an_n,
    output logic        frame_done
);

    localparam int MAX_CYC = (SCAN_DIV > BLANK_CYCLES) ? SCAN_DIV : BLANK_CYCLES;
    localparam int CW      = $clog2(MAX_CYC);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
    localparam logic [CW-1:0] DRIVE_LAST = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] CNT_ZERO   = CW'(0);
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_DRIVE = 1'b1
    } state_t;

    state_t          state_r;
    logic [CW-1:0]   cnt_r;
    logic [1:0]      idx_r;
    logic [15:0]     act_data_r;
    logic [3:0]      act_blank_r;
    logic [3:0]      act_dp_r;
    logic [15:0]     shd_data_r;
    logic [3:0]      shd_blank_r;
    logic [3:0]      shd_dp_r;
    logic            pending_r;
    logic [7:0]      seg_n_r;
    logic [3:0]      an_n_r;
    logic            frame_done_r;

    logic [3:0]      cur_nib_s;
    logic            cur_blank_s;
    logic            cur_dp_s;
    logic [7:0]      drive_code_s;
    logic [3:0]      drive_an_s;
    logic            accept_s;

    // Active-low a..g pattern for one hex nibble (bit 0 = segment a).
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] code;
        case (nib)
            4'h0:    code = 7'h40;
            4'h1:    code = 7'h79;
            4'h2:    code = 7'h24;
            4'h3:    code = 7'h30;
            4'h4:    code = 7'h19;
            4'h5:    code = 7'h12;
            4'h6:    code = 7'h02;
            4'h7:    code = 7'h78;
            4'h8:    code = 7'h00;
            4'h9:    code = 7'h10;
            4'hA:    code = 7'h08;
            4'hB:    code = 7'h03;
            4'hC:    code = 7'h46;
            4'hD:    code = 7'h21;
            4'hE:    code = 7'h06;
            4'hF:    code = 7'h0E;
            default: code = 7'h7F;
        endcase
        return code;
    endfunction

    assign accept_s   = wr_valid & ~pending_r;
    assign wr_ready   = ~pending_r;
    assign seg_n      = seg_n_r;
    assign an_n       = an_n_r;
    assign frame_done = frame_done_r;

    // Select the active nibble and build the segment/anode pattern for the next digit.
    always_comb begin
        cur_nib_s    = act_data_r[{idx_r, 2'b00} +: 4];
        cur_blank_s  = act_blank_r[idx_r];
        cur_dp_s     = act_dp_r[idx_r];
        drive_code_s = {~cur_dp_s, (cur_blank_s ? 7'h7F : hex_to_seg(cur_nib_s))};
        drive_an_s   = ~(4'b0001 << idx_r);
    end

    // Scan state machine, write port and frame-boundary update of the active set.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r      <= ST_BLANK;
            cnt_r        <= CNT_ZERO;
            idx_r        <= 2'd0;
            act_data_r   <= 16'h0000;
            act_blank_r  <= 4'hF;
            act_dp_r     <= 4'h0;
            shd_data_r   <= 16'h0000;
            shd_blank_r  <= 4'h0;
            shd_dp_r     <= 4'h0;
            pending_r    <= 1'b0;
            seg_n_r      <= 8'hFF;
            an_n_r       <= 4'hF;
            frame_done_r <= 1'b0;
        end else begin
            frame_done_r <= 1'b0;
            // A write can only land while nothing is pending, so it never
            // collides with the boundary copy below (which needs pending set).
            if (accept_s) begin
                shd_data_r  <= wr_data;
                shd_blank_r <= wr_blank;
                shd_dp_r    <= wr_dp;
                pending_r   <= 1'b1;
            end
            case (state_r)
                ST_BLANK: begin
                    if (cnt_r == BLANK_LAST) begin
                        state_r <= ST_DRIVE;
                        cnt_r   <= CNT_ZERO;
                        seg_n_r <= drive_code_s;
                        an_n_r  <= drive_an_s;
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                ST_DRIVE: begin
                    if (cnt_r == DRIVE_LAST) begin
                        state_r <= ST_BLANK;
                        cnt_r   <= CNT_ZERO;
                        idx_r   <= idx_r + 2'd1;
                        seg_n_r <= 8'hFF;
                        an_n_r  <= 4'hF;
                        if (idx_r == 2'd3) begin
                            frame_done_r <= 1'b1;
                            if (pending_r) begin
                                act_data_r  <= shd_data_r;
                                act_blank_r <= shd_blank_r;
                                act_dp_r    <= shd_dp_r;
                                pending_r   <= 1'b0;
                            end
                        end
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                default: begin
                    state_r <= ST_BLANK;
                    cnt_r   <= CNT_ZERO;
                    seg_n_r <= 8'hFF;
                    an_n_r  <= 4'hF;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Bench for seven_seg_scan_ctrl: a timeline model (edge count -> digit slot)
// plus a frame-boundary update model predicts every output each cycle.
module tb_seven_seg_scan_ctrl;

    logic        clk;
    logic        reset;
    logic        wr_valid;
    logic        wr_ready;
    logic [15:0] wr_data;
    logic [3:0]  wr_blank;
    logic [3:0]  wr_dp;
    logic [7:0]  seg_n;
    logic [3:0]  an_n;
    logic        frame_done;

    int checks = 0;
    int errors = 0;

    // Reference model state: edges since reset release, active and shadow sets.
    int          ecnt;
    logic [15:0] m_data;
    logic [3:0]  m_blank;
    logic [3:0]  m_dp;
    logic [15:0] s_data;
    logic [3:0]  s_blank;
    logic [3:0]  s_dp;
    logic        m_pend;

    logic [7:0] seg_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                 8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    seven_seg_scan_ctrl #(.SCAN_DIV(4), .BLANK_CYCLES(2)) dut (
        .clk(clk), .reset(reset), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_data(wr_data), .wr_blank(wr_blank), .wr_dp(wr_dp),
        .seg_n(seg_n), .an_n(an_n), .frame_done(frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        ecnt = 0; m_data = 16'h0000; m_blank = 4'hF; m_dp = 4'h0;
        s_data = 16'h0000; s_blank = 4'h0; s_dp = 4'h0; m_pend = 1'b0;
    endtask

    // Advance one edge; inputs are held across the edge, so they are read here.
    task automatic tick();
        logic old_pend;
        @(posedge clk); #1;
        ecnt++;
        old_pend = m_pend;
        if ((ecnt % 24) == 0 && old_pend) begin
            m_data = s_data; m_blank = s_blank; m_dp = s_dp; m_pend = 1'b0;
        end
        if (wr_valid && !old_pend) begin
            s_data = wr_data; s_blank = wr_blank; s_dp = wr_dp; m_pend = 1'b1;
        end
    endtask

    // Slot of 6 edges: positions 0,1 are dead time, 2..5 drive digit (pos/6).
    function automatic logic [3:0] exp_an();
        int p;
        p = ecnt % 24;
        if ((p % 6) >= 2) return ~(4'b0001 << (p / 6));
        else return 4'hF;
    endfunction

    function automatic logic [7:0] exp_seg();
        int p;
        int k;
        logic [3:0] nib;
        logic [7:0] code;
        p = ecnt % 24;
        k = p / 6;
        if ((p % 6) >= 2) begin
            nib = m_data[k*4 +: 4];
            code = seg_tab[nib];
            return {~m_dp[k], (m_blank[k] ? 7'h7F : code[6:0])};
        end else begin
            return 8'hFF;
        end
    endfunction

    function automatic logic exp_fd();
        return (ecnt >= 24) && ((ecnt % 24) == 0);
    endfunction

    task automatic do_reset();
        wr_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        wr_valid = 1'b0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({an_n, seg_n, frame_done, wr_ready} !== {4'hF, 8'hFF, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL reset_hold an=%h seg=%h fd=%b rdy=%b expected an=F seg=FF fd=0 rdy=1", an_n, seg_n, frame_done, wr_ready);
        end
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        for (int i = 0; i < 26; i++) begin
            tick();
            checks++;
            if ({an_n, seg_n, frame_done, wr_ready} !== {exp_an(), exp_seg(), exp_fd(), !m_pend}) begin
                errors++;
                $display("FAIL reset_scan edge=%0d an=%h/%h seg=%h/%h fd=%b/%b rdy=%b/%b", ecnt, an_n, exp_an(), seg_n, exp_seg(), frame_done, exp_fd(), wr_ready, !m_pend);
            end
            if (ecnt == 2 || ecnt == 6 || ecnt == 8) begin
                checks++;
                if (an_n !== ((ecnt == 2) ? 4'hE : (ecnt == 6) ? 4'hF : 4'hD) || seg_n !== 8'hFF) begin
                    errors++;
                    $display("FAIL reset_points edge=%0d an=%h seg=%h", ecnt, an_n, seg_n);
                end
            end
        end
    endtask

    task automatic test_write_applied();
        logic [3:0] an_x  [4] = '{4'hE, 4'hD, 4'hB, 4'h7};
        logic [7:0] seg_x [4] = '{8'h99, 8'hB0, 8'hA4, 8'hF9};
        do_reset();
        tick(); tick();
        wr_valid = 1'b1; wr_data = 16'h1234; wr_blank = 4'h0; wr_dp = 4'h0;
        tick();
        wr_valid = 1'b0;
        checks++;
        if (wr_ready !== 1'b0) begin
            errors++;
            $display("FAIL write_ready_low got=%b expected=0", wr_ready);
        end
        while (ecnt < 48) begin
            tick();
            checks++;
            if ({an_n, seg_n, frame_done, wr_ready} !== {exp_an(), exp_seg(), exp_fd(), !m_pend}) begin
                errors++;
                $display("FAIL write_scan edge=%0d an=%h/%h seg=%h/%h fd=%b/%b rdy=%b/%b", ecnt, an_n, exp_an(), seg_n, exp_seg(), frame_done, exp_fd(), wr_ready, !m_pend);
            end
            if (ecnt >= 26 && ecnt <= 44 && ((ecnt - 26) % 6) == 0) begin
                checks++;
                if (an_n !== an_x[(ecnt - 26) / 6] || seg_n !== seg_x[(ecnt - 26) / 6]) begin
                    errors++;
                    $display("FAIL write_digits edge=%0d an=%h/%h seg=%h/%h", ecnt, an_n, an_x[(ecnt - 26) / 6], seg_n, seg_x[(ecnt - 26) / 6]);
                end
            end
        end
    endtask

    task automatic test_blank_dp();
        logic [7:0] seg_x [4] = '{8'h21, 8'hC6, 8'h83, 8'hFF};
        do_reset();
        wr_valid = 1'b1; wr_data = 16'hABCD; wr_blank = 4'b1000; wr_dp = 4'b0001;
        tick();
        wr_valid = 1'b0;
        while (ecnt < 48) begin
            tick();
            checks++;
            if ({an_n, seg_n, frame_done, wr_ready} !== {exp_an(), exp_seg(), exp_fd(), !m_pend}) begin
                errors++;
                $display("FAIL blank_dp_scan edge=%0d an=%h/%h seg=%h/%h", ecnt, an_n, exp_an(), seg_n, exp_seg());
            end
            if (ecnt >= 26 && ecnt <= 44 && ((ecnt - 26) % 6) == 0) begin
                checks++;
                if (seg_n !== seg_x[(ecnt - 26) / 6]) begin
                    errors++;
                    $display("FAIL blank_dp_digit edge=%0d seg=%h expected=%h", ecnt, seg_n, seg_x[(ecnt - 26) / 6]);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        wr_valid = 1'b1; wr_data = 16'h1111; wr_blank = 4'h0; wr_dp = 4'h0;
        tick();
        wr_data = 16'h2222;
        while (ecnt < 72) begin
            tick();
            if (ecnt >= 25 && m_pend) wr_valid = 1'b0;
            checks++;
            if ({an_n, seg_n, frame_done, wr_ready} !== {exp_an(), exp_seg(), exp_fd(), !m_pend}) begin
                errors++;
                $display("FAIL backpressure_scan edge=%0d an=%h/%h seg=%h/%h fd=%b/%b rdy=%b/%b", ecnt, an_n, exp_an(), seg_n, exp_seg(), frame_done, exp_fd(), wr_ready, !m_pend);
            end
            if (ecnt == 26 || ecnt == 50) begin
                checks++;
                if (seg_n !== ((ecnt == 26) ? 8'hF9 : 8'hA4)) begin
                    errors++;
                    $display("FAIL backpressure_digit edge=%0d seg=%h", ecnt, seg_n);
                end
            end
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        while (ecnt < 47) tick();
        wr_valid = 1'b1; wr_data = 16'($urandom); wr_blank = 4'h0; wr_dp = 4'($urandom);
        tick();
        wr_valid = 1'b0;
        checks++;
        if (frame_done !== 1'b1 || wr_ready !== 1'b0) begin
            errors++;
            $display("FAIL simul_edge48 fd=%b rdy=%b expected fd=1 rdy=0", frame_done, wr_ready);
        end
        while (ecnt < 76) begin
            tick();
            checks++;
            if ({an_n, seg_n, frame_done, wr_ready} !== {exp_an(), exp_seg(), exp_fd(), !m_pend}) begin
                errors++;
                $display("FAIL simul_scan edge=%0d an=%h/%h seg=%h/%h fd=%b/%b rdy=%b/%b", ecnt, an_n, exp_an(), seg_n, exp_seg(), frame_done, exp_fd(), wr_ready, !m_pend);
            end
            if (ecnt == 50) begin
                checks++;
                if (an_n !== 4'hE || seg_n[6:0] !== 7'h7F) begin
                    errors++;
                    $display("FAIL simul_not_applied an=%h seg=%h expected an=E seg[6:0]=7F", an_n, seg_n);
                end
            end
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        wr_valid = 1'b1; wr_data = 16'($urandom); wr_blank = 4'h0; wr_dp = 4'h0;
        tick();
        wr_valid = 1'b0;
        while (ecnt < 30) tick();
        wr_valid = 1'b1; wr_data = 16'($urandom); wr_blank = 4'h0; wr_dp = 4'hF;
        tick();
        wr_valid = 1'b0;
        while (ecnt < 39) tick();
        checks++;
        if (an_n !== 4'hB) begin
            errors++;
            $display("FAIL midreset_pre an=%h expected=B", an_n);
        end
        reset = 1'b1;
        #1;
        checks++;
        if ({an_n, seg_n, frame_done, wr_ready} !== {4'hF, 8'hFF, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL midreset_async an=%h seg=%h fd=%b rdy=%b expected F FF 0 1", an_n, seg_n, frame_done, wr_ready);
        end
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        for (int i = 0; i < 30; i++) begin
            tick();
            checks++;
            if ({an_n, seg_n, frame_done, wr_ready} !== {exp_an(), exp_seg(), exp_fd(), !m_pend}) begin
                errors++;
                $display("FAIL midreset_scan edge=%0d an=%h/%h seg=%h/%h fd=%b/%b rdy=%b/%b", ecnt, an_n, exp_an(), seg_n, exp_seg(), frame_done, exp_fd(), wr_ready, !m_pend);
            end
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 240; i++) begin
            wr_valid = (($urandom % 4) == 0);
            wr_data  = 16'($urandom);
            wr_blank = 4'($urandom);
            wr_dp    = 4'($urandom);
            tick();
            checks++;
            if ({an_n, seg_n, frame_done, wr_ready} !== {exp_an(), exp_seg(), exp_fd(), !m_pend}) begin
                errors++;
                $display("FAIL random_scan edge=%0d an=%h/%h seg=%h/%h fd=%b/%b rdy=%b/%b", ecnt, an_n, exp_an(), seg_n, exp_seg(), frame_done, exp_fd(), wr_ready, !m_pend);
            end
        end
        wr_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b1; wr_valid = 1'b0; wr_data = 16'h0000; wr_blank = 4'h0; wr_dp = 4'h0;
        model_reset();
        test_reset();
        test_write_applied();
        test_blank_dp();
        test_back_to_back();
        test_simultaneous();
        test_mid_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seven_seg_scan_ctrl.md
# seven_seg_scan_ctrl

Time-multiplexed scan controller for the 4-digit common-anode 7-segment display on the lab board. It shares the single active-low segment bus among four digits by cycling the anode selects, with a dead-time gap between digits to suppress ghosting. It also converts four hex nibbles into segment codes. New display contents arrive through a valid/ready write port. Updates apply only at frame boundaries, so a frame never mixes old and new digits. Upstream counter and converter logic feed this block instead of driving `to_7_seg_n` and the anode selects directly.

## Interface
- `SCAN_DIV`, default 100000: clk cycles each digit is driven (1 ms at 100 MHz). Must be ≥ 2.
- `BLANK_CYCLES`, default 1000: dead-time cycles before each digit, with all anodes off. Must be ≥ 1.

Ports:
- `clk`, in, 1: system clock.
- `reset`, in, 1: asynchronous, active-high.
- `wr_valid`, in, 1: a new display word is offered.
- `wr_ready`, out, 1: block can accept a word. Equals ~pending.
- `wr_data`, in, 16: hex nibbles. [3:0] is digit 0 (rightmost, `an_n[0]`); [15:12] is digit 3.
- `wr_blank`, in, 4: per-digit blank. 1 = hex segments off.
- `wr_dp`, in, 4: per-digit decimal point. 1 = dp lit.
- `seg_n`, out, 8: active-low segments {dp,g,f,e,d,c,b,a}. Registered.
- `an_n`, out, 4: active-low digit selects. At most one bit low. Registered.
- `frame_done`, out, 1: one-cycle pulse at each frame boundary. Registered.

## Operation
**Registers**
- Active set: data, blank, dp.
- Shadow set plus `pending` flag.
- Digit index, 2 bits.
- Cycle counter, `$clog2(max(SCAN_DIV, BLANK_CYCLES))` bits.
- State.

**State machine (BLANK / DRIVE)**
- BLANK:
  - `an_n` = 4'hF, `seg_n` = 8'hFF.
  - Lasts `BLANK_CYCLES` cycles, then goes to DRIVE.
- DRIVE:
  - `an_n[idx]` = 0, all other bits 1.
  - `seg_n` = code of the active nibble for that digit.
  - Lasts `SCAN_DIV` cycles, then goes to BLANK with idx+1 (wraps 3→0).

**Segment codes** (bits 6:0, shown with dp off)
- 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8
- 8=80, 9=90, A=88, b=83, C=C6, d=A1, E=86, F=8E
- Blanked digit: bits 6:0 = 7'h7F.
- `seg_n[7]` = ~dp[idx], independent of blank.
- `an_n` is still asserted for a blanked digit.

**Write handshake**
- Transfer occurs when `wr_valid` & `wr_ready` are both high at a clk edge.
- On transfer: the shadow set captures `wr_data`/`wr_blank`/`wr_dp`; `pending` sets, so `wr_ready` is 0 from the next cycle.
- `wr_valid` while `wr_ready` = 0: ignored. The shadow is not overwritten.

**Frame boundary** (the edge ending digit 3's DRIVE)
- If `pending` = 1: shadow copies to active, `pending` clears, and `wr_ready` = 1 the next cycle.
- `frame_done` pulses in either case.
- A write accepted on the same edge as a boundary, with `pending` previously 0, does not apply at that boundary. It applies at the following one.

**Reset** (asynchronous, including mid-frame)
- Outputs: `an_n` = 4'hF, `seg_n` = 8'hFF, `frame_done` = 0, `wr_ready` = 1.
- Internal: state = BLANK, idx = 0, counter = 0, active data = 0, active blank = 4'hF, active dp = 0, `pending` = 0, and the shadow is cleared.
- Any pending write is discarded.

## Timing
- Edge 1 is the first rising clk edge after reset deasserts.
- Slot = `BLANK_CYCLES` + `SCAN_DIV`. Frame = 4 × slot.
- Digit k:
  - `an_n[k]` goes low after edge k·slot + `BLANK_CYCLES`.
  - It returns high after edge (k+1)·slot.
  - `seg_n` changes on the same edges as `an_n`.
- `frame_done` is high for the cycle following edges n·frame (n ≥ 1). The active-set update happens on those same edges.
- Write-to-display latency: the new digit 0 value appears `BLANK_CYCLES` edges after the boundary that applies it.
- `wr_ready` is combinational from `pending`. There are no combinational paths from `wr_valid` to any output.

## Test plan
All scenarios use `SCAN_DIV` = 4, `BLANK_CYCLES` = 2, so slot = 6 and frame = 24.
- **Reset values:** hold reset → `an_n` = F, `seg_n` = FF, `wr_ready` = 1. Release → `an_n` = E after edge 2 with `seg_n` = FF (blanked), `an_n` = F after edge 6, `an_n` = D after edge 8, `frame_done` high after edge 24 only.
- **Write applied at boundary:** write 16'h1234 with blank 0 and dp 0 at edge 3 → `wr_ready` = 0 from edge 4. After edge 24, `frame_done` = 1 and `wr_ready` = 1. After edge 26, `an_n` = E with `seg_n` = 99 ('4'); then `an_n` = D with B0, `an_n` = B with A4, `an_n` = 7 with F9.
- **Blank and dp:** write 16'hAbCd (A,B,C,D) with blank = 4'b1000 and dp = 4'b0001 → digit 0 `seg_n` = 21, digit 1 = C6, digit 2 = 83, digit 3 = FF (hex blanked, dp off).
- **Back-pressure:** write 16'h1111, then hold `wr_valid` with 16'h2222 while `wr_ready` = 0 → display shows 1111. 2222 transfers on the first cycle after `wr_ready` returns and is shown from the next frame.
- **Simultaneous write at boundary:** with `pending` = 0, a write accepted exactly on edge 48 → no active-set change at edge 48; the new value is applied at edge 72.
- **Mid-frame reset:** assert reset while `an_n` = B → `an_n` = F and `seg_n` = FF immediately with no clk. After release, the scan restarts at digit 0 and the display is blank with `pending` = 0.
